multiplier_seq_ctrl: RTL and testbench
======================================

# multiplier_seq_ctrl

Sequential multiplier that computes a WIDTH x WIDTH unsigned product using one shared `multiplier_2bit` cell. The block walks every pair of 2-bit digits of the operands, one pair per clock, and accumulates the shifted partial products. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It is the scheduling layer that lets the small 2x2 cell serve arbitrary even-width multiplies.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. N = WIDTH/2 is the digit count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers operands a, b.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  unsigned result a*b.
- busy  output  1  high while in RUN.

## Operation
- Exactly one `multiplier_2bit` instance. Its inputs are driven from the latched operand digits selected by indices i (a digit) and j (b digit).
- FSM has three states.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear the accumulator, set i=j=0, and go to RUN. Otherwise stay.
  - RUN: each cycle, acc <= acc + (pp << 2*(i+j)), where pp is the 4-bit cell output {c3,c2,c1,c0} zero-extended to 2*WIDTH.
    - j increments every cycle. When j=N-1, j wraps to 0 and i increments.
    - On the cycle with i=N-1 and j=N-1, the last term is added and the state goes to DONE.
  - DONE: out_valid=1. product = acc, held stable. On out_ready, go to IDLE. Otherwise stay, holding everything.
- Accumulator is 2*WIDTH bits wide. The true sum never exceeds (2^WIDTH-1)^2, so no overflow handling is needed.
- in_valid, a and b are ignored outside IDLE. Operands are sampled only on the accepting edge; later input changes have no effect.
- out_ready is ignored outside DONE.
- product retains the last result after drain, until the next accept clears acc. It is not qualified outside DONE.
- busy = (state==RUN).

## Timing
- Reset (rst high at a rising edge):
  - state=IDLE, acc=0, i=j=0, operand registers=0.
  - out_valid=0, busy=0, product=0.
  - in_ready is forced 0 while rst is high and is 1 in the first cycle after rst deasserts.
- Reset mid-RUN or mid-DONE aborts the operation with no result: no out_valid and no partial product left visible. Reset dominates any simultaneous handshake.
- Latency:
  - Input accepted at edge E0; RUN occupies edges E1..E(N*N).
  - out_valid is high starting the cycle after edge E(N*N). For WIDTH=8 that is 16 edges after accept.
- Throughput: at most one result every N*N+2 cycles, because IDLE must be revisited. in_ready rises the cycle after the output handshake edge. There is no same-edge drain-and-accept.
- out_valid, product and in_ready are pure functions of registered state, with no combinational path from inputs. The exception is in_ready's gating by rst.
- out_valid, once high, stays high and product stays stable until the out_ready edge (AXI-style: never withdrawn).
- WIDTH=2: one RUN cycle, then DONE.

## Test plan
- Reset, then accept a=0xFF, b=0xFF at edge 0 -> busy high for 16 cycles; out_valid rises after edge 16 with product=0xFE01; in_ready=0 throughout.
- a=0x00, b=0xB7, then a=0x01, b=0xB7, then a=0xA5, b=0x3C, back-to-back with out_ready tied high -> products 0x0000, 0x00B7, 0x26AC; in_ready returns 1 exactly one cycle after each drain.
- Backpressure: result 0x1234 pending, out_ready low for 10 cycles -> out_valid and product stay stable; toggling in_valid with new a/b during this time is ignored; drains on the first out_ready edge.
- In RUN, change a/b and pulse in_valid -> result still equals the originally latched operands.
- rst asserted at RUN cycle 7 -> next cycle IDLE, out_valid=0, product=0, busy=0; a fresh 0x0D*0x0B afterwards yields 0x008F.
- WIDTH=4 instance: 0xF*0xF -> 0x00E1 after 4 RUN cycles; plus 200 random operand pairs checked against a reference a*b for WIDTH=8.

Source files
------------

// File: rtl/multiplier_seq_ctrl.sv
// rtl/multiplier_seq_ctrl.sv - sequential WIDTHxWIDTH multiplier built on one shared 2x2 cell
//
// multiplier_2bit: combinational 2-bit x 2-bit unsigned multiplier.
//   a, b : 2-bit operand digits
//   c    : 4-bit product {c3,c2,c1,c0}
//
// multiplier_seq_ctrl: walks every (a digit, b digit) pair one per clock and
// accumulates the shifted partial products.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b sampled on the accepting edge)
//   out_valid/out_ready : result handshake (product held until drained)
//   product             : 2*WIDTH-bit accumulator, final a*b once out_valid
//   busy                : high while digit pairs are being accumulated

module multiplier_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] c
);
    logic p10;
    logic p01;
    logic p11;

    assign p10  = a[1] & b[0];
    assign p01  = a[0] & b[1];
    assign p11  = a[1] & b[1];
    assign c[0] = a[0] & b[0];
    assign c[1] = p10 ^ p01;
    assign c[2] = p11 ^ (p10 & p01);
    assign c[3] = p11 & p10 & p01;
endmodule

module multiplier_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [1:0]         a_dig;
    logic [1:0]         b_dig;
    logic [3:0]         pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0] term;
    logic [IW+1:0]      shamt;

    // Digit select: shift the latched operand down by two bits per digit index.
    always_comb begin
        a_sh  = a_q >> {i_q, 1'b0};
        b_sh  = b_q >> {j_q, 1'b0};
        a_dig = a_sh[1:0];
        b_dig = b_sh[1:0];
    end

    multiplier_2bit u_cell (
        .a (a_dig),
        .b (b_dig),
        .c (pp)
    );

    // Partial product weight is 4^(i+j), i.e. a left shift of 2*(i+j).
    always_comb begin
        pp_ext      = '0;
        pp_ext[3:0] = pp;
        shamt       = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};
        term        = pp_ext << shamt;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + term;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // in_ready is the only output that looks at an input: it drops during reset
    // so a producer never sees an accept that the reset would discard.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign product   = acc_q;
endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// tb/tb_multiplier_seq_ctrl.sv - self-checking bench for multiplier_seq_ctrl
module tb_multiplier_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [7:0]  product4;
    logic        busy4;

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    multiplier_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    multiplier_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout at %0t", nm, $time);
    endtask

    // Transaction-level model: phase 0 idle, 1 running (counting N*N cycles), 2 done.
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [15:0] m_exp = '0;
    logic [15:0] m_prod = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_prod  = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   = 16'(a) * 16'(b);
                    m_prod  = '0;
                    m_cnt   = 16;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_prod  = m_exp;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0 && !rst));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("busy", 32'(busy), 32'(m_phase == 1));
            if (m_phase != 1) chk("product", 32'(product), 32'(m_prod));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer x*y, wait for the result, hold it for 'hold' cycles, then drain.
    // With 'tied' the caller keeps out_ready high and draining is implicit.
    task automatic mul(input logic [7:0] x, input logic [7:0] y, input int hold,
                       input bit tied, output logic [15:0] res, output int nbusy);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin step(); t++; end
        if (!in_ready) timeout("wait_in_ready");
        a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        nbusy = 0;
        t = 0;
        while (!out_valid && t < 100) begin
            if (busy) nbusy++;
            step();
            t++;
        end
        if (!out_valid) timeout("wait_out_valid");
        res = product;
        if (!tied) begin
            repeat (hold) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    logic [15:0] res;
    logic [7:0]  rx, ry;
    int          nb;
    int          t4;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("reset_product", 32'(product), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'h1);

        // Full-scale operands and latency.
        mul(8'hFF, 8'hFF, 0, 1'b0, res, nb);
        chk("ff_x_ff", 32'(res), 32'hFE01);
        chk("ff_busy_cycles", 32'(nb), 32'd16);

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        mul(8'h00, 8'hB7, 0, 1'b1, res, nb);
        chk("zero_x_b7", 32'(res), 32'h0000);
        mul(8'h01, 8'hB7, 0, 1'b1, res, nb);
        chk("one_x_b7", 32'(res), 32'h00B7);
        mul(8'hA5, 8'h3C, 0, 1'b1, res, nb);
        chk("a5_x_3c", 32'(res), 32'h26AC);
        step();
        out_ready = 1'b0;
        step();

        // Backpressure with ignored offers while the result is pending.
        mul(8'h14, 8'hE9, 0, 1'b1, res, nb);
        chk("bp_result", 32'(res), 32'h1234);
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a = 8'(k * 37);
            b = 8'(k * 11 + 3);
            step();
            chk("bp_hold", 32'(product), 32'h1234);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_drained", 32'(out_valid), 32'h0);

        // Operand changes and in_valid pulses during RUN are ignored.
        a = 8'h9C; b = 8'h27; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        t4 = 0;
        while (!out_valid && t4 < 100) begin step(); t4++; end
        if (!out_valid) timeout("run_ignore");
        chk("run_ignore", 32'(product), 32'h17C4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of RUN.
        a = 8'h77; b = 8'h66; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_busy", 32'(busy), 32'h0);
        chk("midrun_rst_valid", 32'(out_valid), 32'h0);
        chk("midrun_rst_product", 32'(product), 32'h0);
        mul(8'h0D, 8'h0B, 1, 1'b0, res, nb);
        chk("0d_x_0b", 32'(res), 32'h008F);

        // Random operands against the model, with occasional backpressure.
        for (int k = 0; k < 200; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            mul(rx, ry, int'($urandom_range(0, 2)), 1'b0, res, nb);
            chk("random", 32'(res), 32'(16'(rx) * 16'(ry)));
        end

        // WIDTH=4 instance: N*N = 4 RUN cycles.
        chk("w4_in_ready", 32'(in_ready4), 32'h1);
        a4 = 4'hF; b4 = 4'hF; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        nb = 0;
        t4 = 0;
        while (!out_valid4 && t4 < 50) begin
            if (busy4) nb++;
            step();
            t4++;
        end
        if (!out_valid4) timeout("w4_wait");
        chk("w4_busy_cycles", 32'(nb), 32'd4);
        chk("w4_product", 32'(product4), 32'h00E1);
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        chk("w4_drained", 32'(out_valid4), 32'h0);
        step();
        chk("w4_in_ready_back", 32'(in_ready4), 32'h1);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
